// File: rtl/nmc_pkg.sv
// nmc_pkg: shared FSM state type and default widths for the accumulate/ReLU block
package nmc_pkg;
  typedef enum logic {IDLE, ACCUM} state_t;
  localparam int IN_W_D    = 18;
  localparam int ACC_W_D   = 21;
  localparam int OUT_W_D   = 4;
  localparam int DIM_D     = 64;
  localparam int SHIFT_W_D = 5;
endpackage

// File: rtl/nmc_lane.sv
// nmc_lane: one lane -- accumulate, overflow detect, ReLU, shift, clamp (NMC_SAT_EN selects saturating accumulator); ports: clk, rst_n, beat/last strobes, din, shift -> res, ovf
module nmc_lane #(
  parameter int IN_W    = 18,
  parameter int ACC_W   = 21,
  parameter int OUT_W   = 4,
  parameter int SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               beat,
  input  logic               last,
  input  logic [IN_W-1:0]    din,
  input  logic [SHIFT_W-1:0] shift,
  output logic [OUT_W-1:0]   res,
  output logic               ovf
);
  logic [ACC_W-1:0] acc, acc_next, pos, shifted;
  logic [ACC_W:0]   wide;
  always_comb begin
    wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-IN_W){din[IN_W-1]}}, din};
    ovf  = wide[ACC_W] != wide[ACC_W-1];
`ifdef NMC_SAT_EN
    acc_next = ovf ? {wide[ACC_W], {(ACC_W-1){~wide[ACC_W]}}} : wide[ACC_W-1:0];
`else
    acc_next = wide[ACC_W-1:0];
`endif
    pos     = acc_next[ACC_W-1] ? '0 : acc_next;
    shifted = pos >> shift;
    res     = |shifted[ACC_W-1:OUT_W] ? '1 : shifted[OUT_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (beat) acc <= last ? '0 : acc_next;
endmodule

// File: rtl/nmc_accum_relu.sv
// nmc_accum_relu: DIM-lane partial-sum accumulator with ReLU/shift/clamp requantisation; ports: clk, rst_n, in_valid/in_ready/in_last/in_data/cfg_shift in, out_valid/out_ready/out_data/grp_beats/ovf out; NMC_SAT_EN selects saturating accumulators
module nmc_accum_relu
  import nmc_pkg::*;
#(
  parameter int IN_W    = IN_W_D,
  parameter int ACC_W   = ACC_W_D,
  parameter int OUT_W   = OUT_W_D,
  parameter int DIM     = DIM_D,
  parameter int SHIFT_W = SHIFT_W_D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [IN_W*DIM-1:0]  in_data,
  input  logic [SHIFT_W-1:0]   cfg_shift,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W*DIM-1:0] out_data,
  output logic [7:0]           grp_beats,
  output logic                 ovf
);
  state_t               state, state_next;
  logic [SHIFT_W-1:0]   shift_q, shift_eff;
  logic [7:0]           cnt, cnt_inc;
  logic [DIM-1:0]       lane_ovf;
  logic [OUT_W*DIM-1:0] res;
  logic                 beat;
  assign in_ready  = !(out_valid && !out_ready);
  assign beat      = in_valid && in_ready;
  // a group's first beat arrives in IDLE, so it uses the live cfg_shift
  assign shift_eff = state == IDLE ? cfg_shift : shift_q;
  assign cnt_inc   = cnt == 8'hff ? cnt : cnt + 8'd1;
  always_comb begin
    state_next = beat ? (in_last ? IDLE : ACCUM) : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shift_q   <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      grp_beats <= '0;
    end else begin
      if (beat && state == IDLE) shift_q <= cfg_shift;
      if (beat) cnt <= in_last ? '0 : cnt_inc;
      if (beat && |lane_ovf) ovf <= 1'b1;
      if (beat && in_last) begin
        out_valid <= 1'b1;
        out_data  <= res;
        grp_beats <= cnt_inc;
      end else if (out_ready) out_valid <= 1'b0;
    end
  for (genvar i = 0; i < DIM; i++) begin : g_lane
    nmc_lane #(.IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .beat  (beat),
      .last  (in_last),
      .din   (in_data[i*IN_W +: IN_W]),
      .shift (shift_eff),
      .res   (res[i*OUT_W +: OUT_W]),
      .ovf   (lane_ovf[i])
    );
  end
endmodule
